multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width in bits (legal values 8 to 64).
REQ-002 The block SHALL have parameter ALUControl_WIDTH, default 4, giving the opcode width in bits.
REQ-003 Port CLK SHALL be input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port RST SHALL be input, 1 bit, reset, asynchronous and active-high.
REQ-005 Port Start SHALL be input, 1 bit, an operation request sampled on the CLK edge.
REQ-006 Ports SrcA and SrcB SHALL be inputs, DATA_WIDTH bits each, the operands, sampled only when a Start is accepted.
REQ-007 Port ALU_Control SHALL be input, ALUControl_WIDTH bits, the opcode, sampled only when a Start is accepted.
REQ-008 Port ALU_OUT SHALL be output reg, DATA_WIDTH bits, the primary result (product low half, quotient, or logic/arith result).
REQ-009 Port ALU_HI SHALL be output reg, DATA_WIDTH bits, holding the product high half (MUL), the remainder (DIVU), or 0 for all other opcodes.
REQ-010 Ports Busy and Done SHALL be output regs, 1 bit each; Busy means an operation is in progress, Done is a one-cycle completion pulse.
REQ-011 Flag ports ZERO_Flag, OVF_Flag and DIV0_Flag SHALL be output regs, 1 bit each.

Function
REQ-012 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 MUL (unsigned), 0110 SLT (signed), 0111 NOR, 1000 SLTU, 1001 DIVU; all other codes SHALL produce ALU_OUT=0 and ALU_HI=0.
REQ-013 The FSM SHALL have exactly four states: IDLE, MUL, DIV and DONE.
REQ-014 Start SHALL be accepted only in IDLE; a Start in any other state SHALL be ignored and SHALL NOT corrupt operands or results.
REQ-015 For a single-cycle opcode, IDLE SHALL go to DONE on an accepted Start, with results registered on that same edge.
REQ-016 For MUL, IDLE SHALL go to MUL; the block SHALL use iterative shift-add at one bit per cycle for DATA_WIDTH cycles, then go to DONE.
REQ-017 For DIVU, IDLE SHALL go to DIV; the block SHALL use iterative restoring division at one bit per cycle for DATA_WIDTH cycles, then go to DONE.
REQ-018 DONE SHALL always return to IDLE on the next edge.
REQ-019 Done SHALL be high only in DONE, for exactly one cycle.
REQ-020 Busy SHALL be high in MUL, DIV and DONE, and low in IDLE.
REQ-021 Latency SHALL be: single-cycle ops have Done high 1 cycle after the Start edge; MUL and DIVU have Done high DATA_WIDTH+1 cycles after the Start edge.
REQ-022 Maximum throughput SHALL be one single-cycle op per 2 cycles.
REQ-023 ALU_OUT, ALU_HI and all flags SHALL be valid while Done is high and SHALL hold until the next accepted operation's Done.
REQ-024 MUL SHALL produce the full 2*DATA_WIDTH-bit product, split as {ALU_HI, ALU_OUT}.
REQ-025 ADD and SUB SHALL wrap modulo 2^DATA_WIDTH.
REQ-026 OVF_Flag SHALL be set on signed overflow for ADD and SUB, and SHALL be 0 for all other opcodes.
REQ-027 SLT SHALL compare the operands as two's complement; SLTU SHALL compare them unsigned; both SHALL output 1 or 0, zero-extended.
REQ-028 DIVU with SrcB=0 SHALL skip the DIV state (IDLE to DONE, Done 1 cycle after Start) and SHALL give ALU_OUT all ones, ALU_HI=SrcA and DIV0_Flag=1.
REQ-029 DIV0_Flag SHALL be 0 for every other case.
REQ-030 ZERO_Flag SHALL be 1 when the final ALU_OUT equals 0, for every opcode; ALU_HI SHALL NOT affect it.
REQ-031 Intermediate iteration values SHALL NOT appear on ALU_OUT or ALU_HI; the outputs SHALL be updated only on the transition into DONE.

Reset
REQ-032 While RST is high, the FSM SHALL be in IDLE, and ALU_OUT, ALU_HI, Busy, Done, OVF_Flag and DIV0_Flag SHALL be 0.
REQ-033 While RST is high, ZERO_Flag SHALL be 0.
REQ-034 RST asserted mid-MUL or mid-DIV SHALL abort the operation immediately; no Done SHALL follow.
REQ-035 The first Start after RST deasserts SHALL be accepted normally.

Verification
REQ-036 ADD, DATA_WIDTH=32, SrcA=0x7FFFFFFF, SrcB=1 -> Done 1 cycle later; ALU_OUT=0x80000000, OVF_Flag=1, ZERO_Flag=0, Busy high only in the Done cycle.
REQ-037 MUL, SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> Busy for 33 cycles, Done on cycle 33; ALU_HI=0xFFFFFFFE, ALU_OUT=0x00000001.
REQ-038 DIVU 100/7 -> Done on cycle 33 with ALU_OUT=14, ALU_HI=2; DIVU 5/0 -> Done on cycle 1 with ALU_OUT=0xFFFFFFFF, ALU_HI=5, DIV0_Flag=1.
REQ-039 SLT with SrcA=0xFFFFFFFF, SrcB=1 -> ALU_OUT=1; SLTU with the same operands -> ALU_OUT=0, ZERO_Flag=1.
REQ-040 Start ADD 3+4 pulsed on cycles 5 through 10 while a MUL is in progress -> all ignored; MUL result unchanged; exactly one Done.
REQ-041 RST pulsed on cycle 10 of a DIVU -> all outputs 0 asynchronously, no Done; then SUB 5-5 -> ALU_OUT=0, ZERO_Flag=1, Done 1 cycle after Start.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and
// restoring DIVU; results and flags change only on entry into DONE.
//
// state | meaning
// IDLE  | waiting for Start; only state that accepts an operation
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | results valid, Done pulse, returns to IDLE
module multicycle_alu #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALUControl_WIDTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        Start,
  input  logic [DATA_WIDTH-1:0]       SrcA,
  input  logic [DATA_WIDTH-1:0]       SrcB,
  input  logic [ALUControl_WIDTH-1:0] ALU_Control,
  output logic [DATA_WIDTH-1:0]       ALU_OUT,
  output logic [DATA_WIDTH-1:0]       ALU_HI,
  output logic                        Busy,
  output logic                        Done,
  output logic                        ZERO_Flag,
  output logic                        OVF_Flag,
  output logic                        DIV0_Flag
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int DW    = DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ALUControl_WIDTH-1:0] OP_AND  = ALUControl_WIDTH'(4'h0);
  localparam logic [ALUControl_WIDTH-1:0] OP_OR   = ALUControl_WIDTH'(4'h1);
  localparam logic [ALUControl_WIDTH-1:0] OP_ADD  = ALUControl_WIDTH'(4'h2);
  localparam logic [ALUControl_WIDTH-1:0] OP_XOR  = ALUControl_WIDTH'(4'h3);
  localparam logic [ALUControl_WIDTH-1:0] OP_SUB  = ALUControl_WIDTH'(4'h4);
  localparam logic [ALUControl_WIDTH-1:0] OP_MUL  = ALUControl_WIDTH'(4'h5);
  localparam logic [ALUControl_WIDTH-1:0] OP_SLT  = ALUControl_WIDTH'(4'h6);
  localparam logic [ALUControl_WIDTH-1:0] OP_NOR  = ALUControl_WIDTH'(4'h7);
  localparam logic [ALUControl_WIDTH-1:0] OP_SLTU = ALUControl_WIDTH'(4'h8);
  localparam logic [ALUControl_WIDTH-1:0] OP_DIVU = ALUControl_WIDTH'(4'h9);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    opnd_q, opnd_d;   // multiplicand or divisor
  logic [DW-1:0]    acc_q, acc_d;     // product high half or partial remainder
  logic [DW-1:0]    lo_q, lo_d;       // multiplier/product low or dividend/quotient
  logic [DW-1:0]    out_q, out_d, hi_q, hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, div0_q, div0_d;

  logic [DW-1:0] sum, diff, res;
  logic          res_ovf;

  assign sum  = SrcA + SrcB;
  assign diff = SrcA - SrcB;

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (ALU_Control)
      OP_AND:  res = SrcA & SrcB;
      OP_OR:   res = SrcA | SrcB;
      OP_XOR:  res = SrcA ^ SrcB;
      OP_NOR:  res = ~(SrcA | SrcB);
      OP_ADD: begin
        res     = sum;
        res_ovf = (SrcA[DW-1] == SrcB[DW-1]) && (sum[DW-1] != SrcA[DW-1]);
      end
      OP_SUB: begin
        res     = diff;
        res_ovf = (SrcA[DW-1] != SrcB[DW-1]) && (diff[DW-1] != SrcA[DW-1]);
      end
      OP_SLT:  res = DW'($signed(SrcA) < $signed(SrcB));
      OP_SLTU: res = DW'(SrcA < SrcB);
      default: res = '0;
    endcase
  end

  logic [DW:0]   mul_sum, div_shift, div_diff;
  logic [DW-1:0] mul_acc_nx, mul_lo_nx, div_acc_nx, div_lo_nx;
  logic          div_ge;

  assign mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc_nx = mul_sum[DW:1];
  assign mul_lo_nx  = {mul_sum[0], lo_q[DW-1:1]};

  // Partial remainder stays below the divisor, so bit DW of the difference is the borrow.
  assign div_shift  = {acc_q, lo_q[DW-1]};
  assign div_diff   = div_shift - {1'b0, opnd_q};
  assign div_ge     = ~div_diff[DW];
  assign div_acc_nx = div_ge ? div_diff[DW-1:0] : div_shift[DW-1:0];
  assign div_lo_nx  = {lo_q[DW-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    out_d   = out_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          cnt_d = CNT_W'(DW - 1);
          acc_d = '0;
          if (ALU_Control == OP_MUL) begin
            opnd_d  = SrcA;
            lo_d    = SrcB;
            state_d = S_MUL;
          end else if (ALU_Control == OP_DIVU && SrcB != '0) begin
            opnd_d  = SrcB;
            lo_d    = SrcA;
            state_d = S_DIV;
          end else if (ALU_Control == OP_DIVU) begin
            out_d   = '1;
            hi_d    = SrcA;
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
            div0_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            out_d   = res;
            hi_d    = '0;
            zero_d  = (res == '0);
            ovf_d   = res_ovf;
            div0_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_acc_nx;
        lo_d  = mul_lo_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          out_d   = mul_lo_nx;
          hi_d    = mul_acc_nx;
          zero_d  = (mul_lo_nx == '0);
          ovf_d   = 1'b0;
          div0_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_acc_nx;
        lo_d  = div_lo_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          out_d   = div_lo_nx;
          hi_d    = div_acc_nx;
          zero_d  = (div_lo_nx == '0);
          ovf_d   = 1'b0;
          div0_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  assign ALU_OUT   = out_q;
  assign ALU_HI    = hi_q;
  assign ZERO_Flag = zero_q;
  assign OVF_Flag  = ovf_q;
  assign DIV0_Flag = div0_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: vector table for every opcode plus
// sequences for ignored Starts, mid-divide reset and back-to-back issue.
module tb_multicycle_alu;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic [3:0]  ALU_Control = '0;
  logic [31:0] ALU_OUT, ALU_HI;
  logic        Busy, Done, ZERO_Flag, OVF_Flag, DIV0_Flag;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_alu dut (
    .CLK(CLK), .RST(RST), .Start(Start), .SrcA(SrcA), .SrcB(SrcB),
    .ALU_Control(ALU_Control), .ALU_OUT(ALU_OUT), .ALU_HI(ALU_HI),
    .Busy(Busy), .Done(Done), .ZERO_Flag(ZERO_Flag), .OVF_Flag(OVF_Flag),
    .DIV0_Flag(DIV0_Flag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic [31:0] hi;
    logic        z;
    logic        ovf;
    logic        d0;
    int          lat;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int busy_bad;
    @(negedge CLK);
    Start = 1'b1; ALU_Control = v.op; SrcA = v.a; SrcB = v.b;
    @(posedge CLK); #1;
    Start = 1'b0; SrcA = ~v.a; SrcB = ~v.b; ALU_Control = 4'hF;
    lat = 1; busy_bad = 0;
    while (!Done && lat < 100) begin
      if (!Busy) busy_bad++;
      @(posedge CLK); #1;
      lat++;
    end
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d_busy_during", idx), 64'(busy_bad), 64'd0);
    check($sformatf("v%0d_busy_done", idx), 64'(Busy), 64'd1);
    check($sformatf("v%0d_out", idx), 64'(ALU_OUT), 64'(v.out));
    check($sformatf("v%0d_hi", idx), 64'(ALU_HI), 64'(v.hi));
    check($sformatf("v%0d_zero", idx), 64'(ZERO_Flag), 64'(v.z));
    check($sformatf("v%0d_ovf", idx), 64'(OVF_Flag), 64'(v.ovf));
    check($sformatf("v%0d_div0", idx), 64'(DIV0_Flag), 64'(v.d0));
    @(posedge CLK); #1;
    check($sformatf("v%0d_done_width", idx), 64'({Done, Busy}), 64'd0);
    check($sformatf("v%0d_hold", idx), {ALU_HI, ALU_OUT}, {v.hi, v.out});
  endtask

  initial begin
    int dones, done_c, mid_bad;
    logic [31:0] cap_out, cap_hi;
    vec_t sub55;

    //          op     a             b             out           hi            z     ovf   d0    lat
    vecs[0]  = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0,        1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'h1, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'h3, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'h4, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1};
    vecs[5]  = '{4'h4, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'h7, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33};
    vecs[10] = '{4'h5, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 33};
    vecs[11] = '{4'h9, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 33};
    vecs[12] = '{4'h9, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b0, 1'b0, 1'b1, 1};
    vecs[13] = '{4'hF, 32'h00000012, 32'h00000034, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1};
    vecs[14] = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1};
    vecs[15] = '{4'h5, 32'd3,        32'd5,        32'd15,       32'h0,        1'b0, 1'b0, 1'b0, 33};
    vecs[16] = '{4'h9, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 33};
    vecs[17] = '{4'h6, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1};
    vecs[18] = '{4'h4, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1};
    vecs[19] = '{4'hA, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1};
    vecs[20] = '{4'h2, 32'h80000000, 32'h80000000, 32'h00000000, 32'h0,        1'b1, 1'b1, 1'b0, 1};
    sub55    = '{4'h4, 32'd5,        32'd5,        32'd0,        32'h0,        1'b1, 1'b0, 1'b0, 1};

    #12;
    check("reset_outputs", {ALU_HI, ALU_OUT}, 64'd0);
    check("reset_ctrl_flags", 64'({Busy, Done, ZERO_Flag, OVF_Flag, DIV0_Flag}), 64'd0);
    @(negedge CLK); RST = 1'b0;

    for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

    // MUL with ADD Starts during iterations; outputs must hold the previous zero result.
    @(negedge CLK);
    Start = 1'b1; ALU_Control = 4'h5; SrcA = 32'hFFFFFFFF; SrcB = 32'hFFFFFFFF;
    @(posedge CLK); #1;
    Start = 1'b0; ALU_Control = 4'h2; SrcA = 32'd3; SrcB = 32'd4;
    dones = 0; done_c = 0; mid_bad = 0; cap_out = '0; cap_hi = '0;
    for (int c = 1; c < 45; c++) begin
      if (Done) begin
        dones++;
        if (done_c == 0) begin done_c = c; cap_out = ALU_OUT; cap_hi = ALU_HI; end
      end else if (dones == 0 && (ALU_OUT !== 32'd0 || ALU_HI !== 32'd0)) begin
        mid_bad++;
      end
      Start = (c >= 4 && c <= 9);
      @(posedge CLK); #1;
    end
    Start = 1'b0;
    check("ign_done_count", 64'(dones), 64'd1);
    check("ign_done_cycle", 64'(done_c), 64'd33);
    check("ign_result", {cap_hi, cap_out}, 64'hFFFFFFFE_00000001);
    check("ign_no_intermediate", 64'(mid_bad), 64'd0);

    // Reset part-way through a DIVU.
    @(negedge CLK);
    Start = 1'b1; ALU_Control = 4'h9; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge CLK); #1;
    Start = 1'b0;
    for (int c = 1; c < 10; c++) begin @(posedge CLK); #1; end
    @(negedge CLK); RST = 1'b1;
    #1;
    check("rst_async_outputs", {ALU_HI, ALU_OUT}, 64'd0);
    check("rst_async_ctrl_flags", 64'({Busy, Done, ZERO_Flag, OVF_Flag, DIV0_Flag}), 64'd0);
    @(negedge CLK); RST = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK); #1;
      if (Done || Busy) dones++;
    end
    check("rst_abort_no_done", 64'(dones), 64'd0);
    run_vec(sub55, 99);

    // Start held high: one single-cycle op accepted every other cycle.
    @(negedge CLK);
    Start = 1'b1; ALU_Control = 4'h2; SrcA = 32'd3; SrcB = 32'd4;
    dones = 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge CLK); #1;
      if (Done) dones++;
      if (c == 6) Start = 1'b0;
    end
    check("thru_done_count", 64'(dones), 64'd3);
    check("thru_result", 64'(ALU_OUT), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
